mem_ctl_sram: RTL and testbench
===============================

MEM_CTL_SRAM -- requirements
Module: mem_ctl_sram

Interface
REQ-001 Parameter ADDR_W, default 4, memory address width in bits (depth 2**ADDR_W words).
REQ-002 Parameter DATA_W, default 8, memory word width in bits.
REQ-003 Parameter LATENCY, default 3, cycles from request acceptance to mem_done assertion; legal range 1..15.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 mem_write  input  1  write request level from the controller, held until mem_done is seen.
REQ-007 mem_read  input  1  read request level from the controller, held until mem_done is seen.
REQ-008 mem_addr  input  ADDR_W  word address, sampled at acceptance.
REQ-009 mem_wdata  input  DATA_W  write data, sampled at acceptance.
REQ-010 mem_rdata  output  DATA_W  registered read data, valid while mem_done=1 after a read.
REQ-011 mem_done  output  1  registered completion level; four-phase handshake with mem_write/mem_read.
REQ-012 proto_err  output  1  sticky protocol-violation flag.

Function
REQ-013 FSM states: IDLE, BUSY, DONE; encoding is binary, 2 bits.
REQ-014 IDLE: when mem_write or mem_read is sampled 1, capture mem_addr, mem_wdata and op (write if mem_write=1, else read), load counter with LATENCY-1, go BUSY.
REQ-015 Both mem_write and mem_read sampled 1 in IDLE: accept as write, set proto_err.
REQ-016 BUSY: counter decrements each cycle; at counter=0 go DONE and assert mem_done on the same edge.
REQ-017 Request accepted at edge k: mem_done is 1 after edge k+LATENCY; LATENCY=1 means BUSY lasts one cycle.
REQ-018 Write commits to the array on the BUSY->DONE edge, using the captured address and data.
REQ-019 Read loads mem_rdata from the array at the captured address on the BUSY->DONE edge.
REQ-020 mem_rdata holds its value until the next read completes; writes never change mem_rdata.
REQ-021 DONE: mem_done stays 1 while the captured-op request is 1; when both requests are sampled 0, mem_done drops on that edge and FSM goes IDLE.
REQ-022 Request dropped while in BUSY: abort, no array write, mem_rdata unchanged, set proto_err, go IDLE with mem_done=0.
REQ-023 Changes on mem_addr/mem_wdata after acceptance have no effect on the operation in flight.
REQ-024 A new request is accepted only in IDLE, so back-to-back operations are separated by at least one cycle with mem_done=0.
REQ-025 proto_err clears only on reset.

Reset
REQ-026 On rst_n=0: FSM=IDLE, counter=0, mem_done=0, mem_rdata=0, proto_err=0, captured registers=0.
REQ-027 Reset mid-operation aborts it; an uncommitted write is discarded; array contents are not cleared.
REQ-028 First request is accepted on the first rising edge with rst_n=1.

Configuration
REQ-029 Macro MEM_CTL_SRAM_PARITY_EN defined: each array word stores an even-parity bit computed at commit, read checks parity on the BUSY->DONE edge, mismatch sets proto_err.
REQ-030 Macro MEM_CTL_SRAM_PARITY_EN undefined: no parity bit is stored, array width is DATA_W, proto_err reflects only REQ-015/REQ-022.

Structure
REQ-031 Shared package mem_ctl_pkg holds the FSM state typedef (IDLE/BUSY/DONE) and default ADDR_W/DATA_W/LATENCY constants.
REQ-032 One sub-module, mem_ctl_sram_array: synchronous-write, registered-read storage array, parity bit included under the macro.
REQ-033 Counter width is 4 bits, sufficient for LATENCY up to 15.

Verification
REQ-034 Write addr=5 data=0xA5, LATENCY=3: mem_done rises 3 edges after acceptance; drop mem_write -> mem_done=0 next edge.
REQ-035 Read addr=5 after REQ-034: mem_rdata=0xA5 together with mem_done=1, and held after mem_done falls.
REQ-036 mem_write and mem_read both 1 at addr=2 data=0x3C: write performed, proto_err=1, later read of addr 2 returns 0x3C.
REQ-037 mem_write dropped after one BUSY cycle at addr=7 data=0xFF: no mem_done, proto_err=1, read of addr 7 returns prior value.
REQ-038 rst_n pulsed low while in BUSY for write addr=1 data=0x11: mem_done=0, FSM IDLE, read of addr 1 returns prior value.
REQ-039 With MEM_CTL_SRAM_PARITY_EN: force a flipped stored bit at addr=3, then read addr 3 -> proto_err=1 with mem_done=1.

Source files
------------

// File: rtl/mem_ctl_sram_pkg.sv
// ============================================================================
// Package : mem_ctl_pkg
// Brief   : Shared FSM state type and default geometry/latency constants for
//           the SRAM memory controller.
// Config  : MEM_CTL_SRAM_PARITY_EN (see mem_ctl_sram_array)
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_ctl_pkg;

  localparam int C_ADDR_W  = 4;
  localparam int C_DATA_W  = 8;
  localparam int C_LATENCY = 3;
  localparam int C_CNT_W   = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

`default_nettype wire

// File: rtl/mem_ctl_sram_if.sv
// ============================================================================
// Interface : mem_ctl_sram_if
// Brief     : Request/completion bus between a controller (master) and the
//             SRAM controller (slave). Four-phase level handshake.
// Rev       : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mem_ctl_sram_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
);
  logic              mem_write;
  logic              mem_read;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_done;
  logic              proto_err;

  modport master (
    output mem_write, mem_read, mem_addr, mem_wdata,
    input  mem_rdata, mem_done, proto_err
  );

  modport slave (
    input  mem_write, mem_read, mem_addr, mem_wdata,
    output mem_rdata, mem_done, proto_err
  );
endinterface

`default_nettype wire

// File: rtl/mem_ctl_sram_array.sv
// ============================================================================
// Module : mem_ctl_sram_array
// Brief  : Synchronous-write storage array with a registered read port. The
//          read register only loads on a read strobe, so it holds the last
//          read word across writes and idle cycles.
// Config : MEM_CTL_SRAM_PARITY_EN - store an even-parity bit per word and
//          flag a parity mismatch on every read strobe.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_ctl_sram_array #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  wire logic              clk,
  input  wire logic              rst_n,
  input  wire logic              we_i,
  input  wire logic              re_i,
  input  wire logic [ADDR_W-1:0] addr_i,
  input  wire logic [DATA_W-1:0] wdata_i,
  output logic      [DATA_W-1:0] rdata_o,
  output logic                   par_err_o
);

`ifdef MEM_CTL_SRAM_PARITY_EN
  localparam int WORD_W = DATA_W + 1;
`else
  localparam int WORD_W = DATA_W;
`endif
  localparam int DEPTH = 2 ** ADDR_W;

  logic [WORD_W-1:0] mem_q [DEPTH];
  logic [WORD_W-1:0] word_wr;
  logic [WORD_W-1:0] word_rd;
  logic [DATA_W-1:0] rdata_q;

`ifdef MEM_CTL_SRAM_PARITY_EN
  // Parity bit sits above the data so the whole stored word XORs to zero.
  assign word_wr   = {^wdata_i, wdata_i};
  assign word_rd   = mem_q[addr_i];
  assign par_err_o = re_i & (^word_rd);
`else
  assign word_wr   = wdata_i;
  assign word_rd   = mem_q[addr_i];
  assign par_err_o = 1'b0;
`endif

  // Storage: written on commit only; deliberately not reset.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[addr_i] <= word_wr;
  end

  // Read data register: loads only on a completing read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    rdata_q <= '0;
    else if (re_i) rdata_q <= word_rd[DATA_W-1:0];
  end

  assign rdata_o = rdata_q;

endmodule

`default_nettype wire

// File: rtl/mem_ctl_sram.sv
// ============================================================================
// Module : mem_ctl_sram
// Brief  : SRAM controller with a fixed access latency. Accepts one level
//          request in IDLE, waits LATENCY cycles, commits/reads the array on
//          the BUSY->DONE edge and holds mem_done until the request drops.
//          Protocol violations (both requests, request dropped early, parity
//          mismatch when enabled) set a sticky proto_err.
// Config : MEM_CTL_SRAM_PARITY_EN - enables per-word parity in the array.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_ctl_sram
  import mem_ctl_pkg::*;
#(
  parameter int ADDR_W  = C_ADDR_W,
  parameter int DATA_W  = C_DATA_W,
  parameter int LATENCY = C_LATENCY   // legal range 1..15 (4-bit counter)
) (
  input  wire logic      clk,
  input  wire logic      rst_n,
  mem_ctl_sram_if.slave  bus
);

  state_e             state_q, state_d;
  logic [C_CNT_W-1:0] cnt_q, cnt_d;
  logic               op_wr_q, op_wr_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [DATA_W-1:0]  wdata_q, wdata_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic               arr_we, arr_re;
  logic               par_err;
  logic               req_held;

  // The request that keeps the in-flight operation alive is the one captured.
  assign req_held = op_wr_q ? bus.mem_write : bus.mem_read;

  // State and captured-request registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_wr_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_wr_q <= op_wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic and array strobes.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_wr_d = op_wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    done_d  = done_q;
    err_d   = err_q | par_err;
    arr_we  = 1'b0;
    arr_re  = 1'b0;

    unique case (state_q)
      IDLE: begin
        done_d = 1'b0;
        if (bus.mem_write || bus.mem_read) begin
          op_wr_d = bus.mem_write;
          addr_d  = bus.mem_addr;
          wdata_d = bus.mem_wdata;
          cnt_d   = C_CNT_W'(LATENCY - 1);
          state_d = BUSY;
          if (bus.mem_write && bus.mem_read) err_d = 1'b1;
        end
      end
      BUSY: begin
        if (!req_held) begin
          // Early drop aborts: nothing touches the array or read register.
          err_d   = 1'b1;
          done_d  = 1'b0;
          state_d = IDLE;
        end else if (cnt_q == '0) begin
          arr_we  = op_wr_q;
          arr_re  = !op_wr_q;
          done_d  = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DONE: begin
        if (!bus.mem_write && !bus.mem_read) begin
          done_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        done_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  mem_ctl_sram_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_array (
    .clk       (clk),
    .rst_n     (rst_n),
    .we_i      (arr_we),
    .re_i      (arr_re),
    .addr_i    (addr_q),
    .wdata_i   (wdata_q),
    .rdata_o   (bus.mem_rdata),
    .par_err_o (par_err)
  );

  assign bus.mem_done  = done_q;
  assign bus.proto_err = err_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_ctl_sram.sv
// ============================================================================
// Module : tb_mem_ctl_sram
// Brief  : Directed self-checking bench for mem_ctl_sram. Reads push the
//          model's expected word into a scoreboard queue, popped when
//          mem_done is seen. Parity scenario built only with
//          MEM_CTL_SRAM_PARITY_EN.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_ctl_sram;
  import mem_ctl_pkg::*;

  localparam int AW  = 4;
  localparam int DW  = 8;
  localparam int LAT = 3;

  logic clk;
  logic rst_n;

  mem_ctl_sram_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_ctl_sram #(.ADDR_W(AW), .DATA_W(DW), .LATENCY(LAT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_vec  = 0;
  int unsigned n_fail = 0;

  logic [DW-1:0] model [2**AW];
  logic [DW-1:0] last_rd;
  logic [DW-1:0] exp_q [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Full four-phase transaction; addr/wdata are scrambled right after
  // acceptance to show the captured values are what gets used.
  task automatic do_req(input bit wr, input bit rd, input logic [AW-1:0] a,
                        input logic [DW-1:0] d);
    logic [DW-1:0] e;
    @(negedge clk);
    bus.mem_write = wr;
    bus.mem_read  = rd;
    bus.mem_addr  = a;
    bus.mem_wdata = d;
    if (!wr) exp_q.push_back(model[a]);
    for (int i = 0; i <= LAT; i++) begin
      @(negedge clk);
      if (i == 0) begin
        bus.mem_addr  = ~a;
        bus.mem_wdata = ~d;
      end
      check("done_latency", 32'(bus.mem_done), 32'(i == LAT));
    end
    if (wr) begin
      model[a] = d;
      check("wr_keeps_rdata", 32'(bus.mem_rdata), 32'(last_rd));
    end else if (exp_q.size() == 0) begin
      check("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check("rd_data", 32'(bus.mem_rdata), 32'(e));
      last_rd = e;
    end
    @(negedge clk);
    check("done_hold", 32'(bus.mem_done), 32'd1);
    bus.mem_write = 1'b0;
    bus.mem_read  = 1'b0;
    @(negedge clk);
    check("done_fall", 32'(bus.mem_done), 32'd0);
    check("rdata_hold", 32'(bus.mem_rdata), 32'(last_rd));
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst_n         = 1'b0;
    bus.mem_write = 1'b0;
    bus.mem_read  = 1'b0;
    last_rd       = '0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.mem_write = 1'b0;
    bus.mem_read  = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    last_rd       = '0;
    for (int i = 0; i < 2**AW; i++) model[i] = '0;
    repeat (2) @(negedge clk);
    check("rst_done", 32'(bus.mem_done), 32'd0);
    check("rst_rdata", 32'(bus.mem_rdata), 32'd0);
    check("rst_err", 32'(bus.proto_err), 32'd0);
    rst_n = 1'b1;

    // Basic write then read-back
    do_req(1'b1, 1'b0, 4'd5, 8'hA5);
    do_req(1'b0, 1'b1, 4'd5, 8'h00);
    check("err_clean", 32'(bus.proto_err), 32'd0);

    // Early drop of a write in BUSY
    do_req(1'b1, 1'b0, 4'd7, 8'h42);
    @(negedge clk);
    bus.mem_write = 1'b1;
    bus.mem_addr  = 4'd7;
    bus.mem_wdata = 8'hFF;
    @(negedge clk);
    check("abort_busy_done", 32'(bus.mem_done), 32'd0);
    bus.mem_write = 1'b0;
    for (int i = 0; i < LAT + 1; i++) begin
      @(negedge clk);
      check("abort_no_done", 32'(bus.mem_done), 32'd0);
    end
    check("abort_err", 32'(bus.proto_err), 32'd1);
    check("abort_idle", 32'(dut.state_q), 32'(IDLE));
    do_req(1'b0, 1'b1, 4'd7, 8'h00);

    // Both requests: write wins, error flagged
    pulse_reset();
    check("err_cleared", 32'(bus.proto_err), 32'd0);
    do_req(1'b1, 1'b1, 4'd2, 8'h3C);
    check("both_err", 32'(bus.proto_err), 32'd1);
    do_req(1'b0, 1'b1, 4'd2, 8'h00);

    // Reset in the middle of a write
    pulse_reset();
    do_req(1'b1, 1'b0, 4'd1, 8'h22);
    @(negedge clk);
    bus.mem_write = 1'b1;
    bus.mem_addr  = 4'd1;
    bus.mem_wdata = 8'h11;
    @(negedge clk);
    rst_n         = 1'b0;
    bus.mem_write = 1'b0;
    last_rd       = '0;
    #1;
    check("rst_mid_done", 32'(bus.mem_done), 32'd0);
    check("rst_mid_idle", 32'(dut.state_q), 32'(IDLE));
    @(negedge clk);
    rst_n = 1'b1;
    do_req(1'b0, 1'b1, 4'd1, 8'h00);
    check("rst_mid_err", 32'(bus.proto_err), 32'd0);

`ifdef MEM_CTL_SRAM_PARITY_EN
    // Corrupt the stored parity bit of addr 3; data stays intact
    pulse_reset();
    do_req(1'b1, 1'b0, 4'd3, 8'h5A);
    dut.u_array.mem_q[3][DW] = ~dut.u_array.mem_q[3][DW];
    @(negedge clk);
    bus.mem_read = 1'b1;
    bus.mem_addr = 4'd3;
    repeat (LAT + 1) @(negedge clk);
    check("par_done", 32'(bus.mem_done), 32'd1);
    check("par_err", 32'(bus.proto_err), 32'd1);
    bus.mem_read = 1'b0;
    @(negedge clk);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
